// File: rtl/fp_mul_pkg.sv
// rtl/fp_mul_pkg.sv - FP32 field widths, special constants and flag layout for the multiplier result stage
package fp_mul_pkg;

    localparam int FP_W   = 32;
    localparam int EXP_W  = 8;
    localparam int MAN_W  = 23;

    localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;
    localparam logic [FP_W-1:0]  QNAN    = 32'h7FC00000;

    // Flag vector layout: {ovf, unf, nan, inf, zero}
    localparam int F_ZERO = 0;
    localparam int F_INF  = 1;
    localparam int F_NAN  = 2;
    localparam int F_UNF  = 3;
    localparam int F_OVF  = 4;
    localparam int FLAG_W = 5;

    typedef logic [FLAG_W-1:0] flags_t;

endpackage

// File: rtl/fp32_classify.sv
// rtl/fp32_classify.sv - combinational FP32 classifier and special-value canonicaliser
module fp32_classify
    import fp_mul_pkg::*;
(
    input  logic [FP_W-1:0] value,
    output logic [FP_W-1:0] canon,
    output logic            is_nan,
    output logic            is_inf,
    output logic            is_zero,
    output logic            is_sub
);

    logic [EXP_W-1:0] exp_f;
    logic [MAN_W-1:0] man_f;

    assign exp_f = value[FP_W-2:MAN_W];
    assign man_f = value[MAN_W-1:0];

    // NaNs collapse to one positive quiet NaN; subnormals flush to a zero that keeps the sign.
    always_comb begin
        is_nan  = (exp_f == EXP_MAX) && (man_f != '0);
        is_inf  = (exp_f == EXP_MAX) && (man_f == '0);
        is_sub  = (exp_f == '0) && (man_f != '0);
        canon   = value;
        if (is_nan) begin
            canon = QNAN;
        end else if (is_sub) begin
            canon = {value[FP_W-1], {(FP_W-1){1'b0}}};
        end
        is_zero = (canon[FP_W-2:0] == '0);
    end

endmodule

// File: rtl/fp_mul_result_stage.sv
// rtl/fp_mul_result_stage.sv - registered FIFO output stage for the FP32 multiplier; FP_RES_STATS_EN adds exception counters
module fp_mul_result_stage
    import fp_mul_pkg::*;
#(
    parameter int DEPTH = 4
`ifdef FP_RES_STATS_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [FP_W-1:0]            in_result,
    input  logic                       in_overflow,
    input  logic                       in_underflow,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [FP_W-1:0]            out_result,
    output logic [FLAG_W-1:0]          out_flags,
    output logic [FLAG_W-1:0]          sticky_flags,
    input  logic                       sticky_clr,
`ifdef FP_RES_STATS_EN
    output logic [CNT_W-1:0]           ovf_cnt,
    output logic [CNT_W-1:0]           unf_cnt,
    output logic [CNT_W-1:0]           nan_cnt,
`endif
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH+1);

    logic [FP_W-1:0]  mem_result [DEPTH];
    flags_t           mem_flags  [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    logic             full;
    logic             empty;
    logic             push;
    logic             pop;

    logic [FP_W-1:0]  c_result;
    logic             c_nan;
    logic             c_inf;
    logic             c_zero;
    logic             c_sub;
    flags_t           in_flags;

    fp32_classify u_classify (
        .value   (in_result),
        .canon   (c_result),
        .is_nan  (c_nan),
        .is_inf  (c_inf),
        .is_zero (c_zero),
        .is_sub  (c_sub)
    );

    assign full      = (count == OCC_W'(DEPTH));
    assign empty     = (count == '0);
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Head entry is read straight from storage; forced to zero while nothing is buffered.
    assign out_result = empty ? '0 : mem_result[rd_ptr];
    assign out_flags  = empty ? '0 : mem_flags[rd_ptr];

    // Assemble the entry flags; a flushed subnormal always reports underflow.
    always_comb begin
        in_flags         = '0;
        in_flags[F_ZERO] = c_zero;
        in_flags[F_INF]  = c_inf;
        in_flags[F_NAN]  = c_nan;
        in_flags[F_UNF]  = in_underflow | c_sub;
        in_flags[F_OVF]  = in_overflow;
    end

    // Storage write; contents need no reset because reads are gated by occupancy.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_result[wr_ptr] <= c_result;
            mem_flags[wr_ptr]  <= in_flags;
        end
    end

    // Pointers, occupancy and sticky exception flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            sticky_flags <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + OCC_W'(1);
                2'b01:   count <= count - OCC_W'(1);
                default: count <= count;
            endcase
            sticky_flags <= (sticky_clr ? '0 : sticky_flags) | (push ? in_flags : '0);
        end
    end

`ifdef FP_RES_STATS_EN
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] base, input logic hit);
        return (hit && (base != '1)) ? base + CNT_W'(1) : base;
    endfunction

    // Saturating per-flag counters; a clear and a counted push in one cycle leave the count at 1.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_cnt <= '0;
            unf_cnt <= '0;
            nan_cnt <= '0;
        end else begin
            ovf_cnt <= sat_inc(sticky_clr ? {CNT_W{1'b0}} : ovf_cnt, push && in_flags[F_OVF]);
            unf_cnt <= sat_inc(sticky_clr ? {CNT_W{1'b0}} : unf_cnt, push && in_flags[F_UNF]);
            nan_cnt <= sat_inc(sticky_clr ? {CNT_W{1'b0}} : nan_cnt, push && in_flags[F_NAN]);
        end
    end
`endif

endmodule

// File: tb/tb_fp_mul_result_stage.sv
// tb/tb_fp_mul_result_stage.sv - randomized self-checking bench for fp_mul_result_stage against a queue model
module tb_fp_mul_result_stage;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_result = '0;
    logic        in_overflow = 1'b0;
    logic        in_underflow = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_result;
    logic [4:0]  out_flags;
    logic [4:0]  sticky_flags;
    logic        sticky_clr = 1'b0;
    logic [2:0]  count;
`ifdef FP_RES_STATS_EN
    logic [15:0] ovf_cnt, unf_cnt, nan_cnt;
    int          ovf_m = 0, unf_m = 0, nan_m = 0;
`endif

    int          total = 0;
    int          bad = 0;
    logic [36:0] q[$];
    logic [4:0]  sticky_m = '0;

    always #5 clk = ~clk;

    fp_mul_result_stage #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_result    (in_result),
        .in_overflow  (in_overflow),
        .in_underflow (in_underflow),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_flags    (out_flags),
        .sticky_flags (sticky_flags),
        .sticky_clr   (sticky_clr),
`ifdef FP_RES_STATS_EN
        .ovf_cnt      (ovf_cnt),
        .unf_cnt      (unf_cnt),
        .nan_cnt      (nan_cnt),
`endif
        .count        (count)
    );

    // Reference: stored value and {ovf,unf,nan,inf,zero} from the IEEE field rules.
    function automatic logic [36:0] ref_entry(input logic [31:0] r, input logic ovf, input logic unf);
        logic [7:0]  e;
        logic [22:0] m;
        logic [31:0] v;
        bit          nan, inf, sub, zero;
        e = r[30:23];
        m = r[22:0];
        v = r;
        nan = (e == 8'd255) && (m != 0);
        inf = (e == 8'd255) && (m == 0);
        sub = (e == 8'd0) && (m != 0);
        if (nan) v = 32'h7FC00000;
        if (sub) v = {r[31], 31'd0};
        zero = (v[30:0] == 0);
        return {v, ovf, unf | sub, nan, inf, zero};
    endfunction

    function automatic logic [31:0] rand_value();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 5))
            1: begin r[30:23] = 8'hFF; r[22:0] = '0; end
            2: begin r[30:23] = 8'hFF; r[0] = 1'b1; end
            3: r[30:0] = '0;
            4: begin r[30:23] = 8'h00; r[0] = 1'b1; end
            default: if (r[30:23] == 8'hFF || r[30:23] == 8'h00) r[30:23] = 8'h7F;
        endcase
        return r;
    endfunction

    // One clock of stimulus; the model advances with the edge. Returns after the next falling edge.
    task automatic step(input logic v, input logic [31:0] r, input logic ovf, input logic unf,
                        input logic ordy, input logic clr);
        bit          do_push, do_pop;
        logic [36:0] e;
        in_valid = v; in_result = r; in_overflow = ovf; in_underflow = unf;
        out_ready = ordy; sticky_clr = clr;
        do_push = v && (q.size() < DEPTH);
        do_pop  = ordy && (q.size() > 0);
        e = ref_entry(r, ovf, unf);
        @(posedge clk);
        if (do_pop) void'(q.pop_front());
        if (clr) begin
            sticky_m = '0;
`ifdef FP_RES_STATS_EN
            ovf_m = 0; unf_m = 0; nan_m = 0;
`endif
        end
        if (do_push) begin
            q.push_back(e);
            sticky_m = sticky_m | e[4:0];
`ifdef FP_RES_STATS_EN
            if (e[4] && ovf_m < 65535) ovf_m++;
            if (e[3] && unf_m < 65535) unf_m++;
            if (e[2] && nan_m < 65535) nan_m++;
`endif
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0; sticky_clr = 1'b0;
        in_overflow = 1'b0; in_underflow = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        @(posedge clk);
        q.delete();
        sticky_m = '0;
`ifdef FP_RES_STATS_EN
        ovf_m = 0; unf_m = 0; nan_m = 0;
`endif
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        apply_reset();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        total++; if (count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
        total++; if (sticky_flags !== 5'b0) begin bad++; $display("FAIL reset_sticky got=%b exp=00000", sticky_flags); end
    endtask

    task automatic test_classify();
        logic [31:0] vin  [4] = '{32'h3F960000, 32'hFF800000, 32'hFFC00000, 32'h80000001};
        logic [31:0] vexp [4] = '{32'h3F960000, 32'hFF800000, 32'h7FC00000, 32'h80000000};
        logic [4:0]  fexp [4] = '{5'b00000, 5'b00010, 5'b00100, 5'b01001};
        for (int i = 0; i < 4; i++) begin
            step(1'b1, vin[i], 1'b0, 1'b0, 1'b0, 1'b0);
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL cls%0d_valid got=%b exp=1", i, out_valid); end
            total++; if (out_result !== vexp[i]) begin bad++; $display("FAIL cls%0d_result got=%h exp=%h", i, out_result, vexp[i]); end
            total++; if (out_flags !== fexp[i]) begin bad++; $display("FAIL cls%0d_flags got=%b exp=%b", i, out_flags, fexp[i]); end
            if (i == 1) begin
                total++; if (sticky_flags[1] !== 1'b1) begin bad++; $display("FAIL cls_sticky_inf got=%b exp=1", sticky_flags[1]); end
            end
            step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL cls%0d_drain got=%b exp=0", i, out_valid); end
        end
        total++; if (sticky_flags !== 5'b01111) begin bad++; $display("FAIL cls_sticky_all got=%b exp=01111", sticky_flags); end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 5; i++) step(1'b1, 32'h3F800000 + i, 1'b0, 1'b0, 1'b0, 1'b0);
        total++; if (count !== 3'd4) begin bad++; $display("FAIL bp_full_count got=%0d exp=4", count); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_full_ready got=%b exp=0", in_ready); end
        in_valid = 1'b1; out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_with_oready got=%b exp=0", in_ready); end
        total++; if (count !== 3'd4) begin bad++; $display("FAIL bp_count_hold got=%0d exp=4", count); end
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 32'h40000000 + i, 1'b0, 1'b0, 1'b1, 1'b0);
            if (i == 0) begin
                total++; if (out_result !== 32'h3F800001) begin bad++; $display("FAIL bp_order_first got=%h exp=3f800001", out_result); end
            end
            total++; if (int'(count) !== q.size()) begin bad++; $display("FAIL bp_count got=%0d exp=%0d", count, q.size()); end
            total++; if (out_result !== q[0][36:5]) begin bad++; $display("FAIL bp_order got=%h exp=%h", out_result, q[0][36:5]); end
        end
        for (int i = 0; i < 8 && q.size() > 0; i++) begin
            total++; if (out_result !== q[0][36:5]) begin bad++; $display("FAIL bp_drain got=%h exp=%h", out_result, q[0][36:5]); end
            step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_empty got=%b exp=0", out_valid); end
    endtask

    task automatic test_sticky_clr();
        step(1'b1, 32'h3F800000, 1'b1, 1'b0, 1'b0, 1'b1);
        total++; if (sticky_flags !== 5'b10000) begin bad++; $display("FAIL clr_push_sticky got=%b exp=10000", sticky_flags); end
`ifdef FP_RES_STATS_EN
        total++; if (ovf_cnt !== 16'd1) begin bad++; $display("FAIL clr_push_ovf_cnt got=%0d exp=1", ovf_cnt); end
        total++; if (nan_cnt !== 16'd0) begin bad++; $display("FAIL clr_push_nan_cnt got=%0d exp=0", nan_cnt); end
`endif
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) step(1'b1, rand_value(), 1'b0, 1'b0, 1'b0, 1'b0);
        total++; if (count !== 3'd3) begin bad++; $display("FAIL mid_count_before got=%0d exp=3", count); end
        apply_reset();
        total++; if (count !== 3'd0) begin bad++; $display("FAIL mid_count_after got=%0d exp=0", count); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_out_valid got=%b exp=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 3) != 0, rand_value(), $urandom_range(0, 7) == 0,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
            total++; if (int'(count) !== q.size()) begin bad++; $display("FAIL rnd_count n=%0d got=%0d exp=%0d", n, count, q.size()); end
            total++; if (in_ready !== (q.size() < DEPTH)) begin bad++; $display("FAIL rnd_in_ready n=%0d got=%b", n, in_ready); end
            total++; if (out_valid !== (q.size() > 0)) begin bad++; $display("FAIL rnd_out_valid n=%0d got=%b", n, out_valid); end
            total++; if (sticky_flags !== sticky_m) begin bad++; $display("FAIL rnd_sticky n=%0d got=%b exp=%b", n, sticky_flags, sticky_m); end
            if (q.size() > 0) begin
                total++; if ({out_result, out_flags} !== q[0]) begin bad++; $display("FAIL rnd_head n=%0d got=%h/%b exp=%h/%b", n, out_result, out_flags, q[0][36:5], q[0][4:0]); end
            end
`ifdef FP_RES_STATS_EN
            total++; if ({int'(ovf_cnt), int'(unf_cnt), int'(nan_cnt)} !== {ovf_m, unf_m, nan_m}) begin bad++; $display("FAIL rnd_stats n=%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d", n, ovf_cnt, unf_cnt, nan_cnt, ovf_m, unf_m, nan_m); end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_classify();
        test_backpressure();
        test_sticky_clr();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
